// File: rtl/vga_tile_timing_if.sv
// Scan/render bus between the raster timing generator and the board renderer.
interface vga_tile_timing_if #(
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned TILE_SHIFT = 5,
  parameter int unsigned RGB_W      = 12
);
  logic                        pix_ce;
  logic [CNT_W-1:0]            addr_h;
  logic [CNT_W-1:0]            addr_v;
  logic [CNT_W-TILE_SHIFT-1:0] tile_x;
  logic [CNT_W-TILE_SHIFT-1:0] tile_y;
  logic [TILE_SHIFT-1:0]       sub_x;
  logic [TILE_SHIFT-1:0]       sub_y;
  logic                        frame_start;
  logic                        line_start;
  logic [RGB_W-1:0]            rgb_i;
  logic                        h_sync;
  logic                        v_sync;
  logic                        de;
  logic [RGB_W-1:0]            rgb_o;

  // Timing generator side
  modport master (
    input  pix_ce, rgb_i,
    output addr_h, addr_v, tile_x, tile_y, sub_x, sub_y,
    output frame_start, line_start, h_sync, v_sync, de, rgb_o
  );

  // Renderer / display side
  modport slave (
    output pix_ce, rgb_i,
    input  addr_h, addr_v, tile_x, tile_y, sub_x, sub_y,
    input  frame_start, line_start, h_sync, v_sync, de, rgb_o
  );
endinterface

// File: rtl/vga_tile_timing.sv
// Parametrised VGA raster timing with tile addressing and a latency-matched
// sync/blank path so renderer RGB and syncs leave the block aligned.
module vga_tile_timing #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned TILE_SHIFT = 5,
  parameter int unsigned PIPE_LAT   = 2,
  parameter int unsigned RGB_W      = 12
) (
  input logic           clk,
  input logic           rst,
  vga_tile_timing_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned LAST    = PIPE_LAT - 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } pos_flags_t;

  logic [1:0]       rst_sync_q;
  logic             rst_int;
  logic             tick;
  logic             load;
  logic             h_wrap;
  logic             v_wrap;
  pos_flags_t       flags_c;

  logic [CNT_W-1:0] addr_h_q, addr_h_d;
  logic [CNT_W-1:0] addr_v_q, addr_v_d;
  pos_flags_t [PIPE_LAT-1:0] dl_q, dl_d;
  logic             de_q, de_d;
  logic             h_sync_q, h_sync_d;
  logic             v_sync_q, v_sync_d;
  logic [RGB_W-1:0] rgb_o_q, rgb_o_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  // Reset asserts asynchronously, releases two clocks later in step with clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];
  assign tick    = vid.pix_ce;

  // Counter advance, position flags, delay-line shift and output next-state
  always_comb begin
    h_wrap   = (addr_h_q == H_LAST);
    v_wrap   = (addr_v_q == V_LAST);
    addr_h_d = h_wrap ? '0 : addr_h_q + CNT_W'(1);
    addr_v_d = addr_v_q;
    if (h_wrap) addr_v_d = v_wrap ? '0 : addr_v_q + CNT_W'(1);

    flags_c.act = (addr_h_q < H_ACT) && (addr_v_q < V_ACT);
    flags_c.hs  = (addr_h_q >= HS_BEG) && (addr_h_q < HS_END);
    flags_c.vs  = (addr_v_q >= VS_BEG) && (addr_v_q < VS_END);

    dl_d    = dl_q;
    dl_d[0] = flags_c;
    for (int i = 1; i < int'(PIPE_LAT); i++) dl_d[i] = dl_q[i-1];

    // Held in reset until the synchroniser releases: clear instead of advance
    if (rst_int) begin
      addr_h_d = '0;
      addr_v_d = '0;
      dl_d     = '0;
    end

    de_d     = dl_d[LAST].act;
    h_sync_d = dl_d[LAST].hs ? H_POL : ~H_POL;
    v_sync_d = dl_d[LAST].vs ? V_POL : ~V_POL;
    rgb_o_d  = dl_d[LAST].act ? vid.rgb_i : '0;

    load          = tick || rst_int;
    line_start_d  = tick && h_wrap && !rst_int;
    frame_start_d = line_start_d && v_wrap;
  end

  // State and registered outputs; strobes clear every clk, the rest hold without a tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_h_q      <= '0;
      addr_v_q      <= '0;
      dl_q          <= '0;
      de_q          <= 1'b0;
      h_sync_q      <= ~H_POL;
      v_sync_q      <= ~V_POL;
      rgb_o_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      if (load) begin
        addr_h_q <= addr_h_d;
        addr_v_q <= addr_v_d;
        dl_q     <= dl_d;
        de_q     <= de_d;
        h_sync_q <= h_sync_d;
        v_sync_q <= v_sync_d;
        rgb_o_q  <= rgb_o_d;
      end
    end
  end

  assign vid.addr_h      = addr_h_q;
  assign vid.addr_v      = addr_v_q;
  assign vid.tile_x      = addr_h_q[CNT_W-1:TILE_SHIFT];
  assign vid.tile_y      = addr_v_q[CNT_W-1:TILE_SHIFT];
  assign vid.sub_x       = addr_h_q[TILE_SHIFT-1:0];
  assign vid.sub_y       = addr_v_q[TILE_SHIFT-1:0];
  assign vid.frame_start = frame_start_q;
  assign vid.line_start  = line_start_q;
  assign vid.h_sync      = h_sync_q;
  assign vid.v_sync      = v_sync_q;
  assign vid.de          = de_q;
  assign vid.rgb_o       = rgb_o_q;

endmodule

// File: tb/tb_vga_tile_timing.sv
// Bench for vga_tile_timing: scoreboard of per-cycle expectations from an
// arithmetic raster model, plus directed timing/tile/reset/stall checks.
`timescale 1ns/1ps
module tb_vga_tile_timing;

  localparam int HA = 40, HF = 4, HS = 8, HB = 4;
  localparam int VA = 72, VF = 2, VS = 2, VB = 4;
  localparam int LAT = 3, CW = 12, TS = 5, RW = 12, TW = CW - TS;
  localparam int HT = HA + HF + HS + HB;   // 56
  localparam int VT = VA + VF + VS + VB;   // 80
  localparam int FT = HT * VT;             // 4480

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_tile_timing_if #(.CNT_W(CW), .TILE_SHIFT(TS), .RGB_W(RW)) vid ();

  vga_tile_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CNT_W(CW), .TILE_SHIFT(TS),
    .PIPE_LAT(LAT), .RGB_W(RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .vid (vid)
  );

  typedef struct packed {
    logic [CW-1:0] ah;
    logic [CW-1:0] av;
    logic [TW-1:0] tx;
    logic [TW-1:0] ty;
    logic [TS-1:0] sx;
    logic [TS-1:0] sy;
    logic          fs;
    logic          ls;
    logic          de;
    logic          hs;
    logic          vs;
    logic [RW-1:0] rgb;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  int   t;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    t       = 0;
    cur     = '0;
    cur.hs  = 1'b1;
    cur.vs  = 1'b1;
  endtask

  // Expected outputs after the coming clk edge, from tick count since reset
  task automatic model_step(input bit ce, input logic [RW-1:0] rgb);
    int p, ph, pv, d, dh, dv;
    cur.fs = 1'b0;
    cur.ls = 1'b0;
    if (ce) begin
      t++;
      p  = t % FT;
      ph = p % HT;
      pv = p / HT;
      cur.ah = CW'(ph);
      cur.av = CW'(pv);
      cur.tx = TW'(ph / 32);
      cur.ty = TW'(pv / 32);
      cur.sx = TS'(ph % 32);
      cur.sy = TS'(pv % 32);
      cur.ls = (ph == 0);
      cur.fs = (p == 0);
      if (t < LAT) begin
        cur.de  = 1'b0;
        cur.hs  = 1'b1;
        cur.vs  = 1'b1;
        cur.rgb = '0;
      end else begin
        d  = (t - LAT) % FT;
        dh = d % HT;
        dv = d / HT;
        cur.de  = (dh < HA) && (dv < VA);
        cur.hs  = !((dh >= HA + HF) && (dh < HA + HF + HS));
        cur.vs  = !((dv >= VA + VF) && (dv < VA + VF + VS));
        cur.rgb = cur.de ? rgb : '0;
      end
    end
    q.push_back(cur);
  endtask

  task automatic step(input bit ce, input logic [RW-1:0] rgb);
    @(negedge clk);
    #1;
    vid.pix_ce = ce;
    vid.rgb_i  = rgb;
    model_step(ce, rgb);
  endtask

  task automatic run_until(input int h, input int v, input string name);
    int n;
    n = 0;
    while (!((int'(cur.ah) == h) && (v < 0 || int'(cur.av) == v)) && n < 2 * FT) begin
      step(1'b1, RW'(n * 37 + 5));
      n++;
    end
    if (n >= 2 * FT) begin
      tests++;
      fails++;
      $display("FAIL %s bound expired", name);
    end
  endtask

  // Scoreboard monitor: one expectation per clk edge, checked at the falling edge
  always @(negedge clk) begin
    exp_t e, a;
    if (mon_en && q.size() > 0) begin
      e     = q.pop_front();
      a.ah  = vid.addr_h;
      a.av  = vid.addr_v;
      a.tx  = vid.tile_x;
      a.ty  = vid.tile_y;
      a.sx  = vid.sub_x;
      a.sy  = vid.sub_y;
      a.fs  = vid.frame_start;
      a.ls  = vid.line_start;
      a.de  = vid.de;
      a.hs  = vid.h_sync;
      a.vs  = vid.v_sync;
      a.rgb = vid.rgb_o;
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL scoreboard @%0t actual=%h required=%h", $time, a, e);
      end
    end
  end

  // Tick observer: sync/enable run lengths and strobe periods in pixel ticks
  bit obs_en = 1'b0;
  int ot, last_ls, last_fs, hs_run, de_run, vs_run, lin;
  bit hs_prev, de_prev, vs_prev;

  always @(posedge clk) begin
    if (obs_en && vid.pix_ce) begin
      #1;
      ot++;
      lin = (int'(vid.addr_v) * HT + int'(vid.addr_h) - LAT + FT) % FT;
      if (vid.line_start) begin
        chk("line_start_period", ot - last_ls, HT);
        last_ls = ot;
      end
      if (vid.frame_start) begin
        chk("frame_period", ot - last_fs, FT);
        last_fs = ot;
      end
      if (!vid.h_sync) begin
        if (hs_prev) begin
          chk("hsync_start_h", lin % HT, HA + HF);
          hs_run = 0;
        end
        hs_run++;
      end else if (!hs_prev) chk("hsync_width", hs_run, HS);
      if (vid.de) begin
        if (!de_prev) begin
          chk("de_rise_addr_h", vid.addr_h, LAT);
          de_run = 0;
        end
        de_run++;
      end else if (de_prev) chk("de_width", de_run, HA);
      if (!vid.v_sync) begin
        if (vs_prev) begin
          chk("vsync_start", lin, (VA + VF) * HT);
          vs_run = 0;
        end
        vs_run++;
      end else if (!vs_prev) chk("vsync_width", vs_run, VS * HT);
      hs_prev = vid.h_sync;
      de_prev = vid.de;
      vs_prev = vid.v_sync;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_addr_h"}, vid.addr_h, 0);
    chk({tag, "_addr_v"}, vid.addr_v, 0);
    chk({tag, "_h_sync"}, vid.h_sync, 1);
    chk({tag, "_v_sync"}, vid.v_sync, 1);
    chk({tag, "_de"}, vid.de, 0);
    chk({tag, "_rgb_o"}, vid.rgb_o, 0);
    chk({tag, "_frame_start"}, vid.frame_start, 0);
    chk({tag, "_line_start"}, vid.line_start, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    vid.pix_ce = 1'b0;
    rst        = 1'b0;
    model_reset();
    mon_en     = 1'b1;
    repeat (3) step(1'b0, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    vid.pix_ce = 1'b0;
    vid.rgb_i  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("por");
    release_reset();

    // Pixel tick 1-in-4 clk, constant white: one full frame with observer
    ot = 0; last_ls = 0; last_fs = 0; hs_run = 0; de_run = 0; vs_run = 0;
    hs_prev = 1'b1; de_prev = 1'b0; vs_prev = 1'b1;
    obs_en = 1'b1;
    for (int i = 0; i < (FT + 200) * 4; i++) step((i % 4) == 3, 12'hFFF);
    obs_en = 1'b0;

    // Continuous ticks, varying colour: tile math at (37,70)
    run_until(37, 70, "reach_37_70");
    @(posedge clk);
    #1;
    chk("addr_h_37", vid.addr_h, 37);
    chk("addr_v_70", vid.addr_v, 70);
    chk("tile_x", vid.tile_x, 1);
    chk("sub_x", vid.sub_x, 5);
    chk("tile_y", vid.tile_y, 2);
    chk("sub_y", vid.sub_y, 6);

    // Stall at addr_h=10 for 50 clk, then resume
    run_until(10, -1, "reach_h10");
    repeat (50) step(1'b0, 12'h5A5);
    @(posedge clk);
    #1;
    chk("stall_frozen_h", vid.addr_h, 10);
    step(1'b1, 12'h123);
    @(posedge clk);
    #1;
    chk("stall_resume_h", vid.addr_h, 11);

    // Stall just after a line start: strobe must not repeat
    run_until(0, -1, "reach_h0");
    repeat (50) step(1'b0, 12'h0F0);
    run_until(5, -1, "reach_h5");

    // Mid-line asynchronous reset
    run_until(30, -1, "reach_h30");
    @(negedge clk);
    #2;
    mon_en = 1'b0;
    q.delete();
    vid.pix_ce = 1'b1;
    rst        = 1'b1;
    #1;
    check_reset_values("async");
    @(posedge clk);
    #1;
    chk("reset_hold_addr_h", vid.addr_h, 0);
    release_reset();
    step(1'b1, 12'hABC);
    @(posedge clk);
    #1;
    chk("restart_addr_h", vid.addr_h, 1);
    for (int i = 0; i < 2 * HT + 10; i++) step(1'b1, RW'(i * 11));

    step(1'b0, '0);
    repeat (3) @(negedge clk);
    #2;
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
